// File: rtl/vram_axi_slave.sv
// AXI4-Lite slave for text VRAM (dual-port RAM) and an 8-entry palette, with a display read port.
// Define VRAM_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module vram_axi_slave #(
   parameter int unsigned C_AXI_ADDR_WIDTH = 14,
   parameter int unsigned VRAM_WORDS       = 1200,
   parameter int unsigned PALETTE_BASE     = 2048
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [C_AXI_ADDR_WIDTH-1:0] axi_awaddr,
   input  logic                        axi_awvalid,
   output logic                        axi_awready,
   input  logic [31:0]                 axi_wdata,
   input  logic [3:0]                  axi_wstrb,
   input  logic                        axi_wvalid,
   output logic                        axi_wready,
   output logic [1:0]                  axi_bresp,
   output logic                        axi_bvalid,
   input  logic                        axi_bready,
   input  logic [C_AXI_ADDR_WIDTH-1:0] axi_araddr,
   input  logic                        axi_arvalid,
   output logic                        axi_arready,
   output logic [31:0]                 axi_rdata,
   output logic [1:0]                  axi_rresp,
   output logic                        axi_rvalid,
   input  logic                        axi_rready,
   input  logic [11:0]                 addr,
   output logic [31:0]                 Vram_Word,
   input  logic [2:0]                  colorAddr,
   output logic [31:0]                 colorData
);

   localparam int unsigned WiW    = C_AXI_ADDR_WIDTH - 2;
   localparam int unsigned VramAw = $clog2(VRAM_WORDS);
   localparam logic [WiW-1:0] VramLimit = WiW'(VRAM_WORDS);
   localparam logic [WiW-1:0] PalLo     = WiW'(PALETTE_BASE);
   localparam logic [WiW-1:0] PalHi     = WiW'(PALETTE_BASE + 8);
   localparam logic [11:0]    DispLimit = 12'(VRAM_WORDS);
`ifdef VRAM_SLVERR_EN
   localparam logic [1:0] UnmappedResp = 2'b10;
`else
   localparam logic [1:0] UnmappedResp = 2'b00;
`endif

   typedef enum logic [1:0] {WIdle, WExec, WResp} w_state_e;
   typedef enum logic [1:0] {RIdle, RHold, RWait, RData} r_state_e;

   function automatic logic in_vram(input logic [WiW-1:0] wi);
      return wi < VramLimit;
   endfunction

   function automatic logic in_pal(input logic [WiW-1:0] wi);
      return (wi >= PalLo) && (wi < PalHi);
   endfunction

   w_state_e       w_state_q;
   logic           awready_q, wready_q, bvalid_q;
   logic [1:0]     bresp_q;
   logic           aw_have_q, w_have_q;
   logic [WiW-1:0] waddr_q;
   logic [31:0]    wdata_q;
   logic [3:0]     wstrb_q;

   r_state_e       r_state_q;
   logic           arready_q, rvalid_q;
   logic [1:0]     rresp_q;
   logic [31:0]    rdata_q;
   logic [WiW-1:0] raddr_q;

   logic [31:0]    mem [VRAM_WORDS];
   logic [31:0]    pal_q [8];
   logic [31:0]    vram_word_q;

   logic              aw_take, w_take, ar_take, aw_full, w_full, w_go;
   logic              w_is_vram, w_is_pal, r_is_vram, r_is_pal;
   logic [WiW-1:0]    w_pal_off, r_pal_off;
   logic [VramAw-1:0] w_mem_idx, r_mem_idx, disp_idx;

   always_comb begin
      aw_take   = axi_awvalid & awready_q;
      w_take    = axi_wvalid & wready_q;
      ar_take   = axi_arvalid & arready_q;
      aw_full   = aw_have_q | aw_take;
      w_full    = w_have_q | w_take;
      // The write claims port A in the cycle after both halves are latched
      w_go      = (w_state_q == WIdle) & aw_full & w_full;
      w_is_vram = in_vram(waddr_q);
      w_is_pal  = in_pal(waddr_q);
      r_is_vram = in_vram(raddr_q);
      r_is_pal  = in_pal(raddr_q);
      w_pal_off = waddr_q - PalLo;
      r_pal_off = raddr_q - PalLo;
      w_mem_idx = waddr_q[VramAw-1:0];
      r_mem_idx = raddr_q[VramAw-1:0];
      disp_idx  = addr[VramAw-1:0];
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         w_state_q <= WIdle;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         unique case (w_state_q)
            WIdle: begin
               if (aw_take) begin
                  waddr_q   <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
                  aw_have_q <= 1'b1;
               end
               if (w_take) begin
                  wdata_q  <= axi_wdata;
                  wstrb_q  <= axi_wstrb;
                  w_have_q <= 1'b1;
               end
               if (w_go) begin
                  w_state_q <= WExec;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
               end else begin
                  awready_q <= ~aw_full;
                  wready_q  <= ~w_full;
               end
            end
            WExec: begin
               w_state_q <= WResp;
               bvalid_q  <= 1'b1;
               bresp_q   <= (w_is_vram | w_is_pal) ? 2'b00 : UnmappedResp;
               aw_have_q <= 1'b0;
               w_have_q  <= 1'b0;
            end
            WResp: begin
               if (axi_bready) begin
                  bvalid_q  <= 1'b0;
                  w_state_q <= WIdle;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: w_state_q <= WIdle;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if ((w_state_q == WExec) && w_is_vram) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem[w_mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 8; i++) pal_q[i] <= '0;
      end else if ((w_state_q == WExec) && w_is_pal) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) pal_q[w_pal_off[2:0]][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   // Port B: read-first, so a same-cycle port A write still returns the old word
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vram_word_q <= '0;
      end else begin
         vram_word_q <= (addr < DispLimit) ? mem[disp_idx] : 32'h0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state_q <= RIdle;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         raddr_q   <= '0;
      end else begin
         unique case (r_state_q)
            RIdle: begin
               if (ar_take) begin
                  raddr_q   <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
                  arready_q <= 1'b0;
                  r_state_q <= w_go ? RHold : RWait;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            RHold: r_state_q <= RWait;
            RWait: begin
               if (r_is_vram)     rdata_q <= mem[r_mem_idx];
               else if (r_is_pal) rdata_q <= pal_q[r_pal_off[2:0]];
               else               rdata_q <= 32'h0;
               rresp_q   <= (r_is_vram | r_is_pal) ? 2'b00 : UnmappedResp;
               rvalid_q  <= 1'b1;
               r_state_q <= RData;
            end
            RData: begin
               if (axi_rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  r_state_q <= RIdle;
               end
            end
            default: r_state_q <= RIdle;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{axi_awaddr[1:0], axi_araddr[1:0], w_pal_off[WiW-1:3], r_pal_off[WiW-1:3]};

   assign axi_awready = awready_q;
   assign axi_wready  = wready_q;
   assign axi_bvalid  = bvalid_q;
   assign axi_bresp   = bresp_q;
   assign axi_arready = arready_q;
   assign axi_rvalid  = rvalid_q;
   assign axi_rresp   = rresp_q;
   assign axi_rdata   = rdata_q;
   assign Vram_Word   = vram_word_q;
   assign colorData   = pal_q[colorAddr];

endmodule

// File: tb/tb_vram_axi_slave.sv
// Randomized bench for vram_axi_slave against an array-based model of VRAM and palette.
module tb_vram_axi_slave;

   localparam int unsigned NW = 1200;
   localparam int unsigned PB = 2048;
`ifdef VRAM_SLVERR_EN
   localparam logic [1:0] ErrResp = 2'b10;
`else
   localparam logic [1:0] ErrResp = 2'b00;
`endif

   logic        Clk, Reset;
   logic [13:0] axi_awaddr, axi_araddr;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
   logic [31:0] axi_wdata, axi_rdata;
   logic [3:0]  axi_wstrb;
   logic [1:0]  axi_bresp, axi_rresp;
   logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic [11:0] addr;
   logic [31:0] Vram_Word, colorData;
   logic [2:0]  colorAddr;

   vram_axi_slave dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .axi_awaddr  (axi_awaddr),
      .axi_awvalid (axi_awvalid),
      .axi_awready (axi_awready),
      .axi_wdata   (axi_wdata),
      .axi_wstrb   (axi_wstrb),
      .axi_wvalid  (axi_wvalid),
      .axi_wready  (axi_wready),
      .axi_bresp   (axi_bresp),
      .axi_bvalid  (axi_bvalid),
      .axi_bready  (axi_bready),
      .axi_araddr  (axi_araddr),
      .axi_arvalid (axi_arvalid),
      .axi_arready (axi_arready),
      .axi_rdata   (axi_rdata),
      .axi_rresp   (axi_rresp),
      .axi_rvalid  (axi_rvalid),
      .axi_rready  (axi_rready),
      .addr        (addr),
      .Vram_Word   (Vram_Word),
      .colorAddr   (colorAddr),
      .colorData   (colorData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] ref_vram [NW];
   logic [31:0] ref_pal [8];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   task automatic model_write(input int unsigned wi, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp);
      resp = 2'b00;
      if (wi < NW) ref_vram[wi] = merge(ref_vram[wi], data, strb);
      else if (wi >= PB && wi < PB + 8) ref_pal[wi - PB] = merge(ref_pal[wi - PB], data, strb);
      else resp = ErrResp;
   endtask

   task automatic model_read(input int unsigned wi, output logic [31:0] data, output logic [1:0] resp);
      resp = 2'b00;
      if (wi < NW) data = ref_vram[wi];
      else if (wi >= PB && wi < PB + 8) data = ref_pal[wi - PB];
      else begin
         data = 32'h0;
         resp = ErrResp;
      end
   endtask

   // All tasks start and end #1 after a rising edge
   task automatic axi_write(input int unsigned wi, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp);
      bit aw_hs, w_hs, got_b;
      got_b = 1'b0;
      resp = 2'b11;
      axi_awaddr = 14'(wi * 4);
      axi_wdata = data;
      axi_wstrb = strb;
      axi_awvalid = 1'b1;
      axi_wvalid = 1'b1;
      axi_bready = 1'b1;
      for (int n = 0; n < 20 && !got_b; n++) begin
         aw_hs = axi_awvalid & axi_awready;
         w_hs = axi_wvalid & axi_wready;
         if (axi_bvalid) begin
            got_b = 1'b1;
            resp = axi_bresp;
         end
         @(posedge Clk); #1;
         if (aw_hs) axi_awvalid = 1'b0;
         if (w_hs) axi_wvalid = 1'b0;
      end
      axi_awvalid = 1'b0;
      axi_wvalid = 1'b0;
      axi_bready = 1'b0;
      check_eq("wr_done", 32'(got_b), 32'd1);
   endtask

   task automatic axi_read(input int unsigned wi, output logic [31:0] data, output logic [1:0] resp);
      bit ar_hs, got_r;
      got_r = 1'b0;
      data = 32'hx;
      resp = 2'b11;
      axi_araddr = 14'(wi * 4);
      axi_arvalid = 1'b1;
      axi_rready = 1'b1;
      for (int n = 0; n < 20 && !got_r; n++) begin
         ar_hs = axi_arvalid & axi_arready;
         if (axi_rvalid) begin
            got_r = 1'b1;
            data = axi_rdata;
            resp = axi_rresp;
         end
         @(posedge Clk); #1;
         if (ar_hs) axi_arvalid = 1'b0;
      end
      axi_arvalid = 1'b0;
      axi_rready = 1'b0;
      check_eq("rd_done", 32'(got_r), 32'd1);
   endtask

   task automatic disp_check(input int unsigned a, input string tag);
      addr = 12'(a);
      @(posedge Clk); #1;
      check_eq(tag, Vram_Word, (a < NW) ? ref_vram[a] : 32'h0);
   endtask

   task automatic pal_check(input int unsigned idx, input string tag);
      colorAddr = 3'(idx);
      #1;
      check_eq(tag, colorData, ref_pal[idx]);
   endtask

   logic [1:0]  resp, eresp;
   logic [31:0] data, edata, old;
   int unsigned wi;
   bit aw_hs, w_hs, got_b, got_r;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1;
      {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready} = '0;
      axi_awaddr = '0; axi_araddr = '0; axi_wdata = '0; axi_wstrb = '0;
      addr = '0; colorAddr = '0;
      for (int i = 0; i < 8; i++) ref_pal[i] = 32'h0;

      #3;
      check_eq("rst_awready", 32'(axi_awready), 0);
      check_eq("rst_wready", 32'(axi_wready), 0);
      check_eq("rst_bvalid", 32'(axi_bvalid), 0);
      check_eq("rst_bresp", 32'(axi_bresp), 0);
      check_eq("rst_arready", 32'(axi_arready), 0);
      check_eq("rst_rvalid", 32'(axi_rvalid), 0);
      check_eq("rst_rresp", 32'(axi_rresp), 0);
      check_eq("rst_rdata", axi_rdata, 0);
      check_eq("rst_vram_word", Vram_Word, 0);
      check_eq("rst_color", colorData, 0);
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(posedge Clk); #1;
      check_eq("idle_awready", 32'(axi_awready), 1);
      check_eq("idle_wready", 32'(axi_wready), 1);
      check_eq("idle_arready", 32'(axi_arready), 1);

      // Reset arriving while the write response is pending
      axi_awaddr = 14'((PB + 3) * 4);
      axi_wdata = 32'hDEADBEEF;
      axi_wstrb = 4'hF;
      axi_awvalid = 1'b1;
      axi_wvalid = 1'b1;
      for (int n = 0; n < 10 && !axi_bvalid; n++) begin
         aw_hs = axi_awvalid & axi_awready;
         w_hs = axi_wvalid & axi_wready;
         @(posedge Clk); #1;
         if (aw_hs) axi_awvalid = 1'b0;
         if (w_hs) axi_wvalid = 1'b0;
      end
      check_eq("t1_bvalid_pre", 32'(axi_bvalid), 1);
      model_write(PB + 3, 32'hDEADBEEF, 4'hF, eresp);
      pal_check(3, "t1_pal_written");
      Reset = 1'b1;
      axi_awvalid = 1'b0;
      axi_wvalid = 1'b0;
      #1;
      check_eq("t1_bvalid_async", 32'(axi_bvalid), 0);
      for (int i = 0; i < 8; i++) ref_pal[i] = 32'h0;
      for (int i = 0; i < 8; i++) pal_check(i, "t1_pal_cleared");
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;
      check_eq("t1_awready", 32'(axi_awready), 1);
      check_eq("t1_wready", 32'(axi_wready), 1);

      for (int i = 0; i < NW; i++) begin
         data = $urandom;
         axi_write(i, data, 4'hF, resp);
         model_write(i, data, 4'hF, eresp);
      end

      // Full-word write then AXI and display readback
      axi_write(5, 32'h12345678, 4'hF, resp);
      model_write(5, 32'h12345678, 4'hF, eresp);
      check_eq("t2_bresp", 32'(resp), 0);
      axi_read(5, data, resp);
      check_eq("t2_rdata", data, 32'h12345678);
      check_eq("t2_rresp", 32'(resp), 0);
      disp_check(5, "t2_disp");

      // W ahead of AW, slow bready
      old = ref_vram[9];
      edata = $urandom;
      addr = 12'd9;
      axi_wdata = edata;
      axi_wstrb = 4'hF;
      axi_wvalid = 1'b1;
      @(posedge Clk); #1;
      axi_wvalid = 1'b0;
      check_eq("t3_wready_low", 32'(axi_wready), 0);
      check_eq("t3_awready_high", 32'(axi_awready), 1);
      for (int n = 0; n < 3; n++) begin
         check_eq("t3_no_early_write", Vram_Word, old);
         check_eq("t3_no_early_bvalid", 32'(axi_bvalid), 0);
         @(posedge Clk); #1;
      end
      axi_awaddr = 14'(9 * 4);
      axi_awvalid = 1'b1;
      @(posedge Clk); #1;
      axi_awvalid = 1'b0;
      for (int n = 0; n < 5 && !axi_bvalid; n++) begin
         @(posedge Clk); #1;
      end
      for (int n = 0; n < 4; n++) begin
         check_eq("t3_bvalid_held", 32'(axi_bvalid), 1);
         if (n < 3) begin
            @(posedge Clk); #1;
         end
      end
      check_eq("t3_bresp", 32'(axi_bresp), 0);
      axi_bready = 1'b1;
      @(posedge Clk); #1;
      axi_bready = 1'b0;
      check_eq("t3_bvalid_drop", 32'(axi_bvalid), 0);
      model_write(9, edata, 4'hF, eresp);
      check_eq("t3_disp_new", Vram_Word, ref_vram[9]);

      // Palette byte strobe, colorData is combinational
      axi_write(PB + 2, 32'h01FFE000, 4'h4, resp);
      model_write(PB + 2, 32'h01FFE000, 4'h4, eresp);
      check_eq("t4_bresp", 32'(resp), 0);
      colorAddr = 3'd0;
      #1 colorAddr = 3'd2;
      #1 check_eq("t4_color_strb", colorData, 32'h00FF0000);
      @(posedge Clk); #1;
      axi_write(PB + 2, 32'h01FFE000, 4'hF, resp);
      model_write(PB + 2, 32'h01FFE000, 4'hF, eresp);
      colorAddr = 3'd5;
      #1 colorAddr = 3'd2;
      #1 check_eq("t4_color_full", colorData, 32'h01FFE000);
      @(posedge Clk); #1;

      // Simultaneous write and read to the same word
      axi_write(7, 32'hAAAA5555, 4'hF, resp);
      model_write(7, 32'hAAAA5555, 4'hF, eresp);
      addr = 12'd7;
      axi_awaddr = 14'(7 * 4);
      axi_araddr = 14'(7 * 4);
      axi_wdata = 32'h0000FFFF;
      axi_wstrb = 4'hF;
      check_eq("t5_awready", 32'(axi_awready), 1);
      check_eq("t5_wready", 32'(axi_wready), 1);
      check_eq("t5_arready", 32'(axi_arready), 1);
      axi_awvalid = 1'b1;
      axi_wvalid = 1'b1;
      axi_arvalid = 1'b1;
      @(posedge Clk); #1;
      axi_awvalid = 1'b0;
      axi_wvalid = 1'b0;
      axi_arvalid = 1'b0;
      @(posedge Clk); #1;
      check_eq("t5_disp_old", Vram_Word, 32'hAAAA5555);
      @(posedge Clk); #1;
      check_eq("t5_disp_new", Vram_Word, 32'h0000FFFF);
      model_write(7, 32'h0000FFFF, 4'hF, eresp);
      got_b = 1'b0;
      got_r = 1'b0;
      axi_bready = 1'b1;
      axi_rready = 1'b1;
      for (int n = 0; n < 10 && !(got_b && got_r); n++) begin
         if (axi_bvalid && !got_b) begin
            got_b = 1'b1;
            resp = axi_bresp;
         end
         if (axi_rvalid && !got_r) begin
            got_r = 1'b1;
            data = axi_rdata;
            eresp = axi_rresp;
         end
         @(posedge Clk); #1;
      end
      axi_bready = 1'b0;
      axi_rready = 1'b0;
      check_eq("t5_got_b", 32'(got_b), 1);
      check_eq("t5_got_r", 32'(got_r), 1);
      check_eq("t5_rdata", data, 32'h0000FFFF);
      check_eq("t5_rresp", 32'(eresp), 0);
      check_eq("t5_bresp", 32'(resp), 0);

      // Unmapped word
      axi_write(1500, 32'hCAFEF00D, 4'hF, resp);
      check_eq("t6_bresp", 32'(resp), 32'(ErrResp));
      axi_read(1500, data, resp);
      check_eq("t6_rdata", data, 32'h0);
      check_eq("t6_rresp", 32'(resp), 32'(ErrResp));

      for (int op = 0; op < 300; op++) begin
         int unsigned kind, region;
         logic [3:0] strb;
         kind = $urandom_range(0, 9);
         region = $urandom_range(0, 3);
         if (region < 2) wi = $urandom_range(0, NW - 1);
         else if (region == 2) wi = PB + $urandom_range(0, 7);
         else if ($urandom_range(0, 1) == 0) wi = $urandom_range(NW, PB - 1);
         else wi = $urandom_range(PB + 8, 4095);
         if (kind < 4) begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            axi_write(wi, data, strb, resp);
            model_write(wi, data, strb, eresp);
            check_eq("rnd_bresp", 32'(resp), 32'(eresp));
         end else if (kind < 8) begin
            axi_read(wi, data, resp);
            model_read(wi, edata, eresp);
            check_eq("rnd_rdata", data, edata);
            check_eq("rnd_rresp", 32'(resp), 32'(eresp));
         end else begin
            disp_check($urandom_range(0, 4095), "rnd_disp");
            pal_check($urandom_range(0, 7), "rnd_color");
            @(posedge Clk); #1;
         end
      end

      for (int i = 0; i < NW; i++) disp_check(i, "sweep_disp");
      disp_check(NW, "disp_oob_first");
      disp_check(4095, "disp_oob_last");
      for (int i = 0; i < 8; i++) pal_check(i, "sweep_color");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
